// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the transmitter FSM state encoding and the clocks-per-bit calculation.
// Imported by uart_tx; uart_bit_timer is parameterised by width only.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Clock cycles per serial bit; integer division, remainder dropped.
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts core cycles within the current line phase.
// Ports: clk_i/rst_n_i (sync active-low), clr_i restarts the count, run_i enables
// counting, last_i is the final count of the phase, bit_end_o strobes on that count.
module uart_bit_timer #(
    parameter int CW = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          run_i,
    input  logic [CW-1:0] last_i,
    output logic          bit_end_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end_o = run_i && (cnt_q == last_i);

    // The counter returns to zero at every phase end, so each phase starts at 0
    // without the FSM having to clear it explicitly.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || bit_end_o) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one start bit, PAYLOAD_BITS data bits LSB first, STOP_BITS stop bits.
// Ports: CLK_I, RST_N_I (sync active-low), DATA_I/TX_VALID_I/TX_READY_O word handshake,
// TX_DONE_O one-cycle end-of-frame pulse, TX_O registered serial line (idles high).
module uart_tx
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int STOP_BITS    = 1
) (
    input  logic                    CLK_I,
    input  logic                    RST_N_I,
    input  logic [PAYLOAD_BITS-1:0] DATA_I,
    input  logic                    TX_VALID_I,
    output logic                    TX_READY_O,
    output logic                    TX_DONE_O,
    output logic                    TX_O
);

    localparam int CPB    = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CW_RAW = $clog2(CPB * STOP_BITS);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int IW     = $clog2(PAYLOAD_BITS) + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    // All stop bits are timed as one long phase.
    localparam logic [CW-1:0] STOP_LAST = CW'(CPB * STOP_BITS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(PAYLOAD_BITS - 1);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx: CLK_HZ/BIT_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PAYLOAD_BITS < 1) begin : g_bad_payload
        $error("uart_tx: PAYLOAD_BITS must be at least 1");
    end

    tx_state_t               state_q;
    logic [PAYLOAD_BITS-1:0] shreg_q;
    logic [IW-1:0]           idx_q;
    logic                    tx_q;
    logic                    done_q;

    logic                    accept;
    logic                    bit_end;
    logic [CW-1:0]           phase_last;

    assign TX_READY_O = (state_q == IDLE);
    assign TX_DONE_O  = done_q;
    assign TX_O       = tx_q;

    assign accept     = TX_VALID_I && (state_q == IDLE);
    assign phase_last = (state_q == STOP) ? STOP_LAST : BIT_LAST;

    uart_bit_timer #(
        .CW (CW)
    ) u_bit_timer (
        .clk_i     (CLK_I),
        .rst_n_i   (RST_N_I),
        .clr_i     (accept),
        .run_i     (state_q != IDLE),
        .last_i    (phase_last),
        .bit_end_o (bit_end)
    );

    // The shift register is consumed from bit 0, so the next data bit is always
    // shreg_q[0]; idx_q only tracks how many bits have gone out.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (TX_VALID_I) begin
                        shreg_q <= DATA_I;
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx_q == IDX_LAST) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx at CPB=4: one instance with one stop bit, one with two.
module tb_uart_tx;

    localparam int CPB_TB = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       vld;
    logic       sel;

    logic vld1, rdy1, done1, tx1;
    logic vld2, rdy2, done2, tx2;
    logic tx_s, rdy_s, done_s;

    int n_tests = 0;
    int n_fail  = 0;

    assign vld1   = vld & ~sel;
    assign vld2   = vld & sel;
    assign tx_s   = sel ? tx2   : tx1;
    assign rdy_s  = sel ? rdy2  : rdy1;
    assign done_s = sel ? done2 : done1;

    uart_tx #(
        .PAYLOAD_BITS (8),
        .CLK_HZ       (1_000_000),
        .BIT_RATE     (250_000),
        .STOP_BITS    (1)
    ) u_dut1 (
        .CLK_I      (clk),
        .RST_N_I    (rst_n),
        .DATA_I     (data),
        .TX_VALID_I (vld1),
        .TX_READY_O (rdy1),
        .TX_DONE_O  (done1),
        .TX_O       (tx1)
    );

    uart_tx #(
        .PAYLOAD_BITS (8),
        .CLK_HZ       (1_000_000),
        .BIT_RATE     (250_000),
        .STOP_BITS    (2)
    ) u_dut2 (
        .CLK_I      (clk),
        .RST_N_I    (rst_n),
        .DATA_I     (data),
        .TX_VALID_I (vld2),
        .TX_READY_O (rdy2),
        .TX_DONE_O  (done2),
        .TX_O       (tx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered at the negedge before the accepting edge. line[10] is the first
    // bit on the wire; nbits bits of CPB_TB cycles each are checked, followed by
    // the done cycle. keep_vld leaves TX_VALID_I high for a back-to-back frame.
    // At poke_c (0 = never) a stray request with DATA_I=8'hC3 is pulsed.
    task automatic watch(input logic [10:0] line, input int nbits, input string tag,
                         input logic keep_vld, input logic [7:0] data_after,
                         input int poke_c);
        for (int c = 1; c <= nbits * CPB_TB; c++) begin
            @(negedge clk);
            if (c == 1) begin
                data = data_after;
                if (!keep_vld) vld = 1'b0;
            end
            if (poke_c != 0 && c == poke_c) begin
                vld  = 1'b1;
                data = 8'hC3;
            end
            if (poke_c != 0 && c == poke_c + 1) vld = 1'b0;
            chk($sformatf("%s c%0d tx", tag, c), tx_s, line[10 - (c - 1) / CPB_TB]);
            chk($sformatf("%s c%0d rdy", tag, c), rdy_s, 1'b0);
            chk($sformatf("%s c%0d done", tag, c), done_s, 1'b0);
        end
        @(negedge clk);
        chk($sformatf("%s end done", tag), done_s, 1'b1);
        chk($sformatf("%s end rdy", tag), rdy_s, 1'b1);
        chk($sformatf("%s end tx", tag), tx_s, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // start, data LSB first, stop; first on wire at bit 9
        string      tag;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 10'b0_10100101_1, "a5"};
        vecs[1] = '{8'h01, 10'b0_10000000_1, "01"};
        vecs[2] = '{8'hC4, 10'b0_00100011_1, "c4"};
        vecs[3] = '{8'h80, 10'b0_00000001_1, "80"};
        vecs[4] = '{8'h96, 10'b0_01101001_1, "96"};
        vecs[5] = '{8'h3C, 10'b0_00111100_1, "3c"};

        sel   = 1'b0;
        rst_n = 1'b0;
        vld   = 1'b1;
        data  = 8'hFF;

        // Reset held with a pending request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d tx", i), tx1, 1'b1);
            chk($sformatf("rst%0d rdy", i), rdy1, 1'b1);
            chk($sformatf("rst%0d done", i), done1, 1'b0);
            chk($sformatf("rst%0d tx2", i), tx2, 1'b1);
        end
        rst_n = 1'b1;
        vld   = 1'b0;
        @(negedge clk);
        chk("post_rst tx", tx1, 1'b1);
        chk("post_rst rdy", rdy1, 1'b1);

        // Table of single frames.
        for (int i = 0; i < 6; i++) begin
            data = vecs[i].data;
            vld  = 1'b1;
            chk($sformatf("%s rdy_pre", vecs[i].tag), rdy_s, 1'b1);
            watch({vecs[i].line, 1'b1}, 10, vecs[i].tag, 1'b0, vecs[i].data, 0);
            @(negedge clk);
            chk($sformatf("%s idle done", vecs[i].tag), done_s, 1'b0);
            chk($sformatf("%s idle tx", vecs[i].tag), tx_s, 1'b1);
        end

        // Back-to-back 00 then FF; DATA_I switches to FF right after the first
        // acceptance and the second frame is accepted in the done cycle.
        data = 8'h00;
        vld  = 1'b1;
        watch(11'b0_00000000_1_1, 10, "b2b0", 1'b1, 8'hFF, 0);
        watch(11'b0_11111111_1_1, 10, "b2b1", 1'b0, 8'hFF, 0);
        @(negedge clk);
        chk("b2b idle done", done_s, 1'b0);

        // Stray request with different data during data bit 4 of 8'h3C.
        data = 8'h3C;
        vld  = 1'b1;
        watch(11'b0_00111100_1_1, 10, "poke", 1'b0, 8'h3C, 21);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("poke idle%0d rdy", i), rdy_s, 1'b1);
            chk($sformatf("poke idle%0d tx", i), tx_s, 1'b1);
        end

        // Reset during data bit 3 of 8'h00.
        data = 8'h00;
        vld  = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) vld = 1'b0;
            chk($sformatf("mrst c%0d tx", c), tx_s, 1'b0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst tx", tx_s, 1'b1);
        chk("mrst rdy", rdy_s, 1'b1);
        chk("mrst done", done_s, 1'b0);
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            chk($sformatf("mrst quiet%0d done", i), done_s, 1'b0);
            chk($sformatf("mrst quiet%0d tx", i), tx_s, 1'b1);
        end
        data = 8'h5A;
        vld  = 1'b1;
        watch(11'b0_01011010_1_1, 10, "after_rst", 1'b0, 8'h5A, 0);

        // Two stop bits: 44-cycle frame.
        @(negedge clk);
        sel  = 1'b1;
        data = 8'h81;
        vld  = 1'b1;
        chk("stop2 rdy_pre", rdy_s, 1'b1);
        watch(11'b0_10000001_11, 11, "stop2", 1'b0, 8'h81, 0);
        @(negedge clk);
        chk("stop2 idle done", done_s, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
